// File: rtl/dp_mem_access.sv
// Data-pointer memory access sequencer: one read or write at the pointer address,
// with a bounded ack wait, completion pulse, sticky timeout flag and optional post-increment.
module dp_mem_access #(
    parameter int TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic        post_inc,
    input  logic [15:0] dp_addr,
    input  logic [15:0] wr_data,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_re,
    output logic        mem_we,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] rd_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        inc_dp,
    output logic [1:0]  state_dbg
);

    // Handshake: a request is taken only when it is seen at an edge in IDLE; the memory
    // strobe then stays high until the first edge with mem_ack or until the wait expires.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        FAULT  = 2'd3
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       op_write;
    logic       cap_post_inc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            wait_cnt     <= 8'd0;
            rd_data      <= 16'h0000;
            mem_addr     <= 16'h0000;
            mem_wdata    <= 16'h0000;
            op_write     <= 1'b0;
            cap_post_inc <= 1'b0;
            err          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_req || wr_req) begin
                        mem_addr     <= dp_addr;
                        mem_wdata    <= wr_data;
                        op_write     <= wr_req;
                        cap_post_inc <= post_inc;
                        err          <= 1'b0;
                        wait_cnt     <= 8'd0;
                        state        <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        if (!op_write) begin
                            rd_data <= mem_rdata;
                        end
                        wait_cnt <= 8'd0;
                        state    <= DONE;
                    end else if (wait_cnt == LAST_WAIT) begin
                        // This was the last permitted cycle; give up.
                        wait_cnt <= 8'd0;
                        err      <= 1'b1;
                        state    <= FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE:    state <= IDLE;
                FAULT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Decoded from state so the async reset drops the strobes with no clock edge.
    assign mem_re    = (state == ACCESS) && !op_write;
    assign mem_we    = (state == ACCESS) && op_write;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE) || (state == FAULT);
    assign inc_dp    = (state == DONE) && cap_post_inc;
    assign state_dbg = state;

endmodule

// File: tb/tb_dp_mem_access.sv
// Bench for dp_mem_access: directed cases plus random transactions checked against a
// transaction-level model (strobe length, success/timeout, read data, increment).
module tb_dp_mem_access;

    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_req, wr_req, post_inc;
    logic [15:0] dp_addr, wr_data;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_re, mem_we, mem_ack;
    logic [15:0] mem_rdata, rd_data;
    logic        busy, done, err, inc_dp;
    logic [1:0]  state_dbg;

    int errors = 0;
    int checks = 0;
    logic [15:0] model_rd;
    logic [15:0] exp_q[$];

    dp_mem_access #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .rd_req(rd_req), .wr_req(wr_req), .post_inc(post_inc),
        .dp_addr(dp_addr), .wr_data(wr_data), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .rd_data(rd_data), .busy(busy), .done(done), .err(err), .inc_dp(inc_dp),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ack_at: index of the access cycle carrying mem_ack, or -1 for none.
    task automatic run_txn(input bit rd, input bit wr, input bit pi, input logic [15:0] addr,
                           input logic [15:0] data, input int ack_at, input logic [15:0] rdata,
                           input bit hold_req);
        bit is_wr, ok;
        int n;
        logic [15:0] exp_rd;
        is_wr = wr;
        ok    = (ack_at >= 0) && (ack_at < TIMEOUT);
        n     = ok ? ack_at + 1 : TIMEOUT;
        if (ok && !is_wr) model_rd = rdata;
        exp_q.push_back(model_rd);

        rd_req = rd; wr_req = wr; post_inc = pi; dp_addr = addr; wr_data = data;
        tick();
        if (!hold_req) begin
            rd_req = 1'b0; wr_req = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            check_eq("re_access", mem_re, !is_wr);
            check_eq("we_access", mem_we, is_wr);
            check_eq("addr_access", mem_addr, addr);
            check_eq("wdata_access", mem_wdata, data);
            check_eq("busy_access", busy, 1'b1);
            check_eq("done_access", done, 1'b0);
            check_eq("err_access", err, 1'b0);
            dp_addr   = 16'($urandom);
            wr_data   = 16'($urandom);
            post_inc  = 1'($urandom);
            mem_ack   = (i == ack_at);
            mem_rdata = (i == ack_at) ? rdata : 16'($urandom);
            tick();
        end
        rd_req  = 1'b0; wr_req = 1'b0;
        mem_ack = 1'($urandom);
        mem_rdata = 16'($urandom);
        exp_rd = exp_q.pop_front();
        check_eq("done_pulse", done, 1'b1);
        check_eq("inc_dp", inc_dp, ok && pi);
        check_eq("err_done", err, !ok);
        check_eq("strobe_off", {mem_re, mem_we}, 2'b00);
        check_eq("rd_data", rd_data, exp_rd);
        tick();
        mem_ack = 1'b0;
        check_eq("idle_busy", busy, 1'b0);
        check_eq("idle_done", done, 1'b0);
        check_eq("idle_inc", inc_dp, 1'b0);
        check_eq("idle_err", err, !ok);
        check_eq("idle_addr", mem_addr, addr);
        check_eq("idle_rd_data", rd_data, exp_rd);
    endtask

    initial begin
        rd_req = 0; wr_req = 0; post_inc = 0; dp_addr = 0; wr_data = 0;
        mem_ack = 0; mem_rdata = 0; model_rd = 16'h0000;
        reset = 1'b1;
        #23;
        check_eq("rst_outputs", {mem_re, mem_we, busy, done, err, inc_dp}, 6'd0);
        check_eq("rst_addr", mem_addr, 16'h0000);
        check_eq("rst_wdata", mem_wdata, 16'h0000);
        check_eq("rst_rd_data", rd_data, 16'h0000);
        @(posedge clk); #1;
        reset = 1'b0;
        tick();

        run_txn(1, 0, 1, 16'h1234, 16'h0000, 2, 16'hBEEF, 0);
        run_txn(0, 1, 0, 16'hFFFF, 16'h00A5, 0, 16'h5555, 0);
        run_txn(1, 0, 1, 16'h0042, 16'h0000, -1, 16'h1111, 0);
        run_txn(1, 0, 0, 16'h0043, 16'h0000, TIMEOUT - 1, 16'hCAFE, 0);
        run_txn(1, 0, 1, 16'h0044, 16'h0000, TIMEOUT, 16'h2222, 0);
        run_txn(1, 1, 1, 16'h0100, 16'h7777, 1, 16'h3333, 0);
        run_txn(1, 0, 0, 16'h0200, 16'h0000, 3, 16'h4444, 1);

        // Reset in the middle of an access.
        rd_req = 1'b1; dp_addr = 16'h0ABC;
        tick();
        rd_req = 1'b0;
        tick();
        check_eq("pre_rst_re", mem_re, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("mid_rst_re", mem_re, 1'b0);
        check_eq("mid_rst_busy", busy, 1'b0);
        check_eq("mid_rst_rd_data", rd_data, 16'h0000);
        check_eq("mid_rst_addr", mem_addr, 16'h0000);
        model_rd = 16'h0000;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("post_rst_quiet", {busy, done, inc_dp, mem_re}, 4'd0);
            tick();
        end
        run_txn(1, 0, 1, 16'h0ABC, 16'h0000, 1, 16'hD00D, 0);

        for (int t = 0; t < 40; t++) begin
            bit w;
            w = 1'($urandom);
            run_txn(!w || 1'($urandom), w, 1'($urandom), 16'($urandom), 16'($urandom),
                    $urandom_range(0, TIMEOUT + 2) - 1, 16'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dp_mem_access.md
DP_MEM_ACCESS -- requirements
Module: dp_mem_access

Interface
REQ-001 Parameter TIMEOUT, default 8, maximum ACCESS-state cycles without mem_ack before abort (legal 1..255).
REQ-002 clk  input  1  clock, all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rd_req  input  1  start data-memory read at pointer address.
REQ-005 wr_req  input  1  start data-memory write at pointer address.
REQ-006 post_inc  input  1  pulse inc_dp to pointer on successful completion.
REQ-007 dp_addr  input  16  current data-pointer value (pointer register output).
REQ-008 wr_data  input  16  store data.
REQ-009 mem_addr  output  16  memory address.
REQ-010 mem_wdata  output  16  memory write data.
REQ-011 mem_re  output  1  memory read strobe.
REQ-012 mem_we  output  1  memory write strobe.
REQ-013 mem_ack  input  1  memory completion, single-cycle.
REQ-014 mem_rdata  input  16  memory read data, valid with mem_ack.
REQ-015 rd_data  output  16  last successfully read word, registered.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 done  output  1  one-cycle completion pulse (success or fault).
REQ-018 err  output  1  timeout flag, sticky until next accepted request.
REQ-019 inc_dp  output  1  one-cycle increment request to pointer register.

Function
REQ-020 FSM states SHALL be IDLE, ACCESS, DONE, FAULT; all outputs registered or decoded from state and captured registers only.
REQ-021 IDLE: rd_req or wr_req high at an edge SHALL be accepted; dp_addr, wr_data, post_inc, operation captured; err cleared; next state ACCESS.
REQ-022 rd_req and wr_req high together SHALL perform the write only; read dropped.
REQ-023 Requests while busy SHALL be ignored, not queued.
REQ-024 ACCESS: mem_addr = captured address, mem_wdata = captured data, exactly one of mem_re/mem_we held high every cycle of the state.
REQ-025 mem_ack high in ACCESS: read loads rd_data <= mem_rdata; next state DONE; wait counter cleared.
REQ-026 Each ACCESS cycle without mem_ack SHALL increment the wait counter; ack in the TIMEOUT-th cycle counts as success; no ack after TIMEOUT cycles -> FAULT.
REQ-027 DONE (one cycle): done=1; inc_dp=1 same cycle iff captured post_inc=1; next IDLE.
REQ-028 FAULT (one cycle): done=1, err set to 1, inc_dp=0, rd_data unchanged; next IDLE.
REQ-029 Latency: request at edge N -> strobe from cycle N+1; ack at cycle N+1+k -> done in cycle N+2+k; back-to-back requests accepted in the IDLE cycle following done.
REQ-030 Strobes SHALL be 0 outside ACCESS; mem_ack outside ACCESS ignored; mem_addr/mem_wdata hold last captured values when idle.
REQ-031 No address arithmetic in this block; 0xFFFF passed unchanged, wrap handled by pointer on inc_dp.

Reset
REQ-032 reset SHALL force IDLE, wait counter 0, rd_data, mem_addr, mem_wdata 0x0000, and all 1-bit outputs 0, immediately and asynchronously.
REQ-033 reset during ACCESS SHALL drop strobes without waiting for clk; no done or inc_dp is produced for the aborted access.

Verification
REQ-034 Read, post_inc=1, dp_addr=0x1234, ack after 2 wait cycles with mem_rdata=0xBEEF -> mem_re high 3 cycles at 0x1234, rd_data=0xBEEF, done and inc_dp high together for one cycle.
REQ-035 Write, dp_addr=0xFFFF, wr_data=0x00A5, post_inc=0, immediate ack -> mem_we one cycle with mem_wdata=0x00A5, done pulse, inc_dp=0, rd_data unchanged.
REQ-036 Read, TIMEOUT=8, no ack -> mem_re 8 cycles, then done=1, err=1, inc_dp=0; err clears at next accepted request. Ack on 8th cycle instead -> success, err=0.
REQ-037 rd_req and wr_req same edge -> write only; rd_req asserted while busy -> no second access.
REQ-038 reset asserted mid-ACCESS -> mem_re=0 immediately, busy=0, no done after release; following request completes normally.
